// File: rtl/prog_truth_table_gate_if.sv
// Configuration port of the programmable truth-table gate: serial table load
// handshake plus load status flags.
interface prog_truth_table_gate_if;
    logic cfg_start;
    logic cfg_abort;
    logic cfg_valid;
    logic cfg_bit;
    logic cfg_ready;
    logic cfg_done;
    logic cfg_err;
    logic busy;

    modport master (
        output cfg_start, cfg_abort, cfg_valid, cfg_bit,
        input  cfg_ready, cfg_done, cfg_err, busy
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_valid, cfg_bit,
        output cfg_ready, cfg_done, cfg_err, busy
    );
endinterface

// File: rtl/prog_truth_table_gate.sv
// Run-time programmable N-input truth-table gate. The table is loaded serially into a shadow
// register and committed atomically; the output follows only inputs that held for SETTLE cycles.
module prog_truth_table_gate #(
    parameter int          N_IN    = 3,
    parameter logic [63:0] INIT_TT = 64'h01,
    parameter int          SETTLE  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in,
    output logic            out,
    output logic            out_valid,
    prog_truth_table_gate_if.slave cfg
);
    localparam int TT_W  = 1 << N_IN;
    localparam int BIT_W = N_IN + 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TT_W - 1);
    localparam logic [TT_W-1:0]  TT_RST   = INIT_TT[TT_W-1:0];

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TT_W-1:0]   r_tt;
    logic [TT_W-1:0]   r_shadow;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [N_IN-1:0]   r_in_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out;
    logic              r_out_valid;
    logic              r_cfg_ready;
    logic              r_cfg_done;
    logic              r_cfg_err;
    logic              r_busy;
    logic              w_settled;
    logic              w_accept;
    logic              w_last;
    logic              w_start_run;

    assign w_settled   = (in == r_in_q) && (r_cnt == CNT_MAX);
    assign w_accept    = (r_state == ST_LOAD) && cfg.cfg_valid && !cfg.cfg_abort;
    assign w_last      = (r_bit_idx == LAST_BIT);
    assign w_start_run = (r_state == ST_RUN) && cfg.cfg_start;

    assign out           = r_out;
    assign out_valid     = r_out_valid;
    assign cfg.cfg_ready = r_cfg_ready;
    assign cfg.cfg_done  = r_cfg_done;
    assign cfg.cfg_err   = r_cfg_err;
    assign cfg.busy      = r_busy;

    // Load sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load sequencer next-state; abort outranks a same-cycle bit transfer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (cfg.cfg_start) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (cfg.cfg_abort) begin
                    w_state_nxt = ST_RUN;
                end else if (w_accept && w_last) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Status flags are decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == ST_LOAD);
            r_cfg_done  <= (w_state_nxt == ST_COMMIT);
            r_busy      <= (w_state_nxt != ST_RUN);
        end
    end

    // Sticky protocol error: a bit offered while no load is open; a new load request clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else if (w_start_run) begin
            r_cfg_err <= 1'b0;
        end else if (cfg.cfg_valid && (r_state != ST_LOAD)) begin
            r_cfg_err <= 1'b1;
        end else begin
            r_cfg_err <= r_cfg_err;
        end
    end

    // Shadow table capture and bit pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= {TT_W{1'b0}};
            r_bit_idx <= {BIT_W{1'b0}};
        end else if (w_start_run) begin
            r_shadow  <= {TT_W{1'b0}};
            r_bit_idx <= {BIT_W{1'b0}};
        end else if ((r_state == ST_LOAD) && cfg.cfg_abort) begin
            r_shadow  <= {TT_W{1'b0}};
            r_bit_idx <= {BIT_W{1'b0}};
        end else if (w_accept) begin
            r_shadow[r_bit_idx[N_IN-1:0]] <= cfg.cfg_bit;
            r_bit_idx                     <= r_bit_idx + BIT_W'(1);
        end else begin
            r_shadow  <= r_shadow;
            r_bit_idx <= r_bit_idx;
        end
    end

    // Active table: replaced as a whole only in the commit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt <= TT_RST;
        end else if (r_state == ST_COMMIT) begin
            r_tt <= r_shadow;
        end else begin
            r_tt <= r_tt;
        end
    end

    // Settle filter; a commit restarts the count so the new table is applied only after a full window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q      <= {N_IN{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_q <= in;
            if (r_state == ST_COMMIT) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (in != r_in_q) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_settled) begin
                r_out       <= r_tt[in];
                r_out_valid <= 1'b1;
            end else begin
                r_out       <= r_out;
                r_out_valid <= r_out_valid;
            end
        end
    end
endmodule
